// File: rtl/cdb_arb_if.sv
// Completion-channel and CDB broadcast bundle for cdb_arb.
// master: functional units / CDB consumers; slave: the arbiter.
interface cdb_arb_if #(
    parameter int N_CH   = 4,
    parameter int N_CDB  = 2,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 5,
    parameter int RS_W   = 4,
    parameter int XLEN   = 32
);
    logic [N_CH-1:0]         in_valid;
    logic [N_CH-1:0]         in_ready;
    logic [N_CH*PREG_W-1:0]  in_preg;
    logic [N_CH*ROB_W-1:0]   in_rob_idx;
    logic [N_CH*XLEN-1:0]    in_result;
    logic [N_CH*XLEN-1:0]    in_rs2_value;
    logic [N_CH-1:0]         in_take_branch;
    logic [N_CH-1:0]         in_wr_mem;
    logic [N_CH*RS_W-1:0]    in_rs_idx;

    logic [N_CDB-1:0]        cdb_en;
    logic [N_CDB*PREG_W-1:0] cdb_preg;
    logic [N_CDB*ROB_W-1:0]  out_rob_idx;
    logic [N_CDB*XLEN-1:0]   out_result;
    logic [N_CDB*XLEN-1:0]   out_rs2_value;
    logic [N_CDB-1:0]        out_take_branch;
    logic [N_CDB-1:0]        out_wr_mem;
    logic [N_CDB*RS_W-1:0]   out_rs_idx;

    modport master (
        output in_valid, in_preg, in_rob_idx, in_result, in_rs2_value,
               in_take_branch, in_wr_mem, in_rs_idx,
        input  in_ready, cdb_en, cdb_preg, out_rob_idx, out_result,
               out_rs2_value, out_take_branch, out_wr_mem, out_rs_idx
    );

    modport slave (
        input  in_valid, in_preg, in_rob_idx, in_result, in_rs2_value,
               in_take_branch, in_wr_mem, in_rs_idx,
        output in_ready, cdb_en, cdb_preg, out_rob_idx, out_result,
               out_rs2_value, out_take_branch, out_wr_mem, out_rs_idx
    );
endinterface

// File: rtl/cdb_arb.sv
// Common data bus arbiter: per-channel completion FIFOs drained onto N_CDB
// registered broadcast lanes by a rotating-priority scan.
module cdb_arb #(
    parameter int N_CH   = 4,
    parameter int N_CDB  = 2,
    parameter int DEPTH  = 2,
    parameter int PREG_W = 6,
    parameter int ROB_W  = 5,
    parameter int RS_W   = 4,
    parameter int XLEN   = 32
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     squash,
    cdb_arb_if.slave bus
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PREG_W-1:0] preg;
        logic [ROB_W-1:0]  rob_idx;
        logic [XLEN-1:0]   result;
        logic [XLEN-1:0]   rs2_value;
        logic              take_branch;
        logic              wr_mem;
        logic [RS_W-1:0]   rs_idx;
    } entry_t;

    entry_t           mem_q    [N_CH][DEPTH];
    entry_t           mem_d    [N_CH][DEPTH];
    logic [CNT_W-1:0] cnt_q    [N_CH];
    logic [CNT_W-1:0] cnt_d    [N_CH];
    logic [PTR_W-1:0] wr_ptr_q [N_CH];
    logic [PTR_W-1:0] wr_ptr_d [N_CH];
    logic [PTR_W-1:0] rd_ptr_q [N_CH];
    logic [PTR_W-1:0] rd_ptr_d [N_CH];
    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [N_CDB-1:0] cdb_en_q, cdb_en_d;
    entry_t           lane_q   [N_CDB];
    entry_t           lane_d   [N_CDB];

    entry_t           in_ent   [N_CH];
    logic [N_CH-1:0]  ready_w;
    logic [N_CH-1:0]  push;
    logic [N_CH-1:0]  grant;
    logic [N_CH-1:0]  pop;
    logic [N_CDB-1:0] lane_vld;
    logic [CH_W-1:0]  lane_ch  [N_CDB];
    logic [CH_W-1:0]  last_ch;
    int               scan_ch;
    int               n_lane;

    // Input unpack and acceptance; ready depends only on registered counts.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            in_ent[i].preg        = bus.in_preg[i*PREG_W +: PREG_W];
            in_ent[i].rob_idx     = bus.in_rob_idx[i*ROB_W +: ROB_W];
            in_ent[i].result      = bus.in_result[i*XLEN +: XLEN];
            in_ent[i].rs2_value   = bus.in_rs2_value[i*XLEN +: XLEN];
            in_ent[i].take_branch = bus.in_take_branch[i];
            in_ent[i].wr_mem      = bus.in_wr_mem[i];
            in_ent[i].rs_idx      = bus.in_rs_idx[i*RS_W +: RS_W];
            ready_w[i]            = (cnt_q[i] < CNT_W'(DEPTH));
            push[i]               = bus.in_valid[i] && ready_w[i] && !squash;
        end
    end

    // Rotating scan: the k-th nonempty channel from rr_ptr lands on lane k.
    always_comb begin
        grant    = '0;
        lane_vld = '0;
        n_lane   = 0;
        scan_ch  = 0;
        last_ch  = rr_ptr_q;
        for (int l = 0; l < N_CDB; l++) lane_ch[l] = '0;
        for (int j = 0; j < N_CH; j++) begin
            scan_ch = int'(rr_ptr_q) + j;
            if (scan_ch >= N_CH) scan_ch = scan_ch - N_CH;
            if (cnt_q[scan_ch] != '0 && n_lane < N_CDB) begin
                grant[scan_ch]   = 1'b1;
                lane_vld[n_lane] = 1'b1;
                lane_ch[n_lane]  = CH_W'(scan_ch);
                last_ch          = CH_W'(scan_ch);
                n_lane           = n_lane + 1;
            end
        end
        pop = squash ? '0 : grant;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (!squash && grant != '0) begin
            rr_ptr_d = (last_ch == CH_W'(N_CH - 1)) ? '0 : last_ch + CH_W'(1);
        end
    end

    // FIFO bookkeeping; a flush empties every channel but leaves priority alone.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < N_CH; i++) begin
            if (push[i]) mem_d[i][wr_ptr_q[i]] = in_ent[i];
            if (squash) begin
                cnt_d[i]    = '0;
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
            end else begin
                cnt_d[i]    = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
                wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PTR_W'(1) : wr_ptr_q[i];
                rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + PTR_W'(1) : rd_ptr_q[i];
            end
        end
    end

    always_comb begin
        cdb_en_d = '0;
        for (int l = 0; l < N_CDB; l++) begin
            lane_d[l] = '0;
            if (!squash && lane_vld[l]) begin
                cdb_en_d[l] = 1'b1;
                lane_d[l]   = mem_q[lane_ch[l]][rd_ptr_q[lane_ch[l]]];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q <= '0;
            cdb_en_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]    <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
            for (int l = 0; l < N_CDB; l++) lane_q[l] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cdb_en_q <= cdb_en_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]    <= cnt_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
            for (int l = 0; l < N_CDB; l++) lane_q[l] <= lane_d[l];
        end
    end

    // Storage needs no reset: counts gate every read.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_comb begin
        bus.in_ready = ready_w;
        bus.cdb_en   = cdb_en_q;
        for (int l = 0; l < N_CDB; l++) begin
            bus.cdb_preg[l*PREG_W +: PREG_W]    = lane_q[l].preg;
            bus.out_rob_idx[l*ROB_W +: ROB_W]   = lane_q[l].rob_idx;
            bus.out_result[l*XLEN +: XLEN]      = lane_q[l].result;
            bus.out_rs2_value[l*XLEN +: XLEN]   = lane_q[l].rs2_value;
            bus.out_take_branch[l]              = lane_q[l].take_branch;
            bus.out_wr_mem[l]                   = lane_q[l].wr_mem;
            bus.out_rs_idx[l*RS_W +: RS_W]      = lane_q[l].rs_idx;
        end
    end
endmodule

// File: tb/tb_cdb_arb.sv
// Directed bench for cdb_arb: latency, lane ordering, backpressure,
// fairness, squash and asynchronous reset.
module tb_cdb_arb;
    localparam int N_CH   = 4;
    localparam int N_CDB  = 2;
    localparam int DEPTH  = 2;
    localparam int PREG_W = 6;
    localparam int ROB_W  = 5;
    localparam int RS_W   = 4;
    localparam int XLEN   = 32;

    logic clock  = 1'b0;
    logic reset  = 1'b0;
    logic squash = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    cdb_arb_if #(.N_CH(N_CH), .N_CDB(N_CDB), .PREG_W(PREG_W), .ROB_W(ROB_W),
                 .RS_W(RS_W), .XLEN(XLEN)) bus ();

    cdb_arb #(.N_CH(N_CH), .N_CDB(N_CDB), .DEPTH(DEPTH), .PREG_W(PREG_W),
              .ROB_W(ROB_W), .RS_W(RS_W), .XLEN(XLEN)) dut (
        .clock  (clock),
        .reset  (reset),
        .squash (squash),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [PREG_W-1:0] lpreg(input int l);
        return bus.cdb_preg[l*PREG_W +: PREG_W];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_in();
        bus.in_valid       = '0;
        bus.in_preg        = '0;
        bus.in_rob_idx     = '0;
        bus.in_result      = '0;
        bus.in_rs2_value   = '0;
        bus.in_take_branch = '0;
        bus.in_wr_mem      = '0;
        bus.in_rs_idx      = '0;
    endtask

    task automatic drive(input int ch, input logic [PREG_W-1:0] preg,
                         input logic [ROB_W-1:0] rob, input logic [XLEN-1:0] res);
        bus.in_valid[ch]                  = 1'b1;
        bus.in_preg[ch*PREG_W +: PREG_W]  = preg;
        bus.in_rob_idx[ch*ROB_W +: ROB_W] = rob;
        bus.in_result[ch*XLEN +: XLEN]    = res;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        squash = 1'b0;
        clear_in();
        reset = 1'b0;
        #4;
        reset = 1'b1;
    endtask

    task automatic single_push(input string tag);
        clear_in();
        drive(2, 6'h0A, 5'd3, 32'h100);
        bus.in_rs2_value[2*XLEN +: XLEN] = 32'h55;
        bus.in_take_branch[2]            = 1'b1;
        bus.in_rs_idx[2*RS_W +: RS_W]    = 4'd7;
        tick();
        clear_in();
        total++; if (bus.cdb_en !== 2'b00) begin bad++; $display("FAIL %s_bypass got=%b exp=00", tag, bus.cdb_en); end
        tick();
        total++; if (bus.cdb_en !== 2'b01) begin bad++; $display("FAIL %s_en got=%b exp=01", tag, bus.cdb_en); end
        total++; if (lpreg(0) !== 6'h0A) begin bad++; $display("FAIL %s_preg got=%h exp=0a", tag, lpreg(0)); end
        total++; if (bus.out_rob_idx[4:0] !== 5'd3) begin bad++; $display("FAIL %s_rob got=%0d exp=3", tag, bus.out_rob_idx[4:0]); end
        total++; if (bus.out_result[31:0] !== 32'h100) begin bad++; $display("FAIL %s_result got=%h exp=100", tag, bus.out_result[31:0]); end
        total++; if (bus.out_rs2_value[31:0] !== 32'h55) begin bad++; $display("FAIL %s_rs2 got=%h exp=55", tag, bus.out_rs2_value[31:0]); end
        total++; if (bus.out_take_branch !== 2'b01 || bus.out_wr_mem !== 2'b00) begin bad++; $display("FAIL %s_flags got=%b/%b exp=01/00", tag, bus.out_take_branch, bus.out_wr_mem); end
        total++; if (bus.out_rs_idx !== 8'h07) begin bad++; $display("FAIL %s_rs got=%h exp=07", tag, bus.out_rs_idx); end
        total++; if (lpreg(1) !== 6'h00 || bus.out_result[63:32] !== 32'h0) begin bad++; $display("FAIL %s_lane1_zero got=%h/%h exp=0", tag, lpreg(1), bus.out_result[63:32]); end
        tick();
        total++; if (bus.cdb_en !== 2'b00) begin bad++; $display("FAIL %s_one_cycle got=%b exp=00", tag, bus.cdb_en); end
    endtask

    task automatic test_reset();
        clear_in();
        #2;
        total++; if (bus.cdb_en !== 2'b00) begin bad++; $display("FAIL reset_en got=%b exp=00", bus.cdb_en); end
        total++; if (bus.in_ready !== 4'hF) begin bad++; $display("FAIL reset_ready got=%h exp=f", bus.in_ready); end
        total++; if (bus.cdb_preg !== '0 || bus.out_result !== '0) begin bad++; $display("FAIL reset_payload got=%h/%h exp=0", bus.cdb_preg, bus.out_result); end
        #5;
        reset = 1'b1;
        tick();
        total++; if (bus.in_ready !== 4'hF) begin bad++; $display("FAIL reset_ready_after got=%h exp=f", bus.in_ready); end
    endtask

    task automatic test_single();
        do_reset();
        single_push("single");
    endtask

    task automatic test_all_channels();
        do_reset();
        for (int c = 0; c < N_CH; c++) drive(c, PREG_W'(6'h10 + c), ROB_W'(c), XLEN'(c));
        tick();
        clear_in();
        total++; if (bus.in_ready !== 4'hF) begin bad++; $display("FAIL all4_ready got=%h exp=f", bus.in_ready); end
        tick();
        total++; if (bus.cdb_en !== 2'b11 || lpreg(0) !== 6'h10 || lpreg(1) !== 6'h11) begin bad++; $display("FAIL all4_cycA got=%b %h %h exp=11 10 11", bus.cdb_en, lpreg(0), lpreg(1)); end
        tick();
        total++; if (bus.cdb_en !== 2'b11 || lpreg(0) !== 6'h12 || lpreg(1) !== 6'h13) begin bad++; $display("FAIL all4_cycB got=%b %h %h exp=11 12 13", bus.cdb_en, lpreg(0), lpreg(1)); end
        tick();
        total++; if (bus.cdb_en !== 2'b00) begin bad++; $display("FAIL all4_idle got=%b exp=00", bus.cdb_en); end
        // rr_ptr back at 0: channel 0 must outrank channel 3
        drive(3, 6'h13, 5'd3, 32'h3);
        drive(0, 6'h10, 5'd0, 32'h0);
        tick();
        clear_in();
        tick();
        total++; if (bus.cdb_en !== 2'b11 || lpreg(0) !== 6'h10 || lpreg(1) !== 6'h13) begin bad++; $display("FAIL all4_rr0 got=%b %h %h exp=11 10 13", bus.cdb_en, lpreg(0), lpreg(1)); end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(0, 6'h01, 5'd0, 32'h0);
        drive(1, 6'h02, 5'd0, 32'h0);
        tick();
        clear_in();
        tick();
        total++; if (bus.cdb_en !== 2'b11 || lpreg(0) !== 6'h01 || lpreg(1) !== 6'h02) begin bad++; $display("FAIL bp_setup got=%b %h %h exp=11 01 02", bus.cdb_en, lpreg(0), lpreg(1)); end
        drive(1, 6'h21, 5'd1, 32'h0);
        drive(2, 6'h32, 5'd2, 32'h0);
        drive(3, 6'h33, 5'd3, 32'h0);
        tick();
        clear_in();
        drive(1, 6'h22, 5'd2, 32'h0);
        tick();
        total++; if (bus.cdb_en !== 2'b11 || lpreg(0) !== 6'h32 || lpreg(1) !== 6'h33) begin bad++; $display("FAIL bp_others got=%b %h %h exp=11 32 33", bus.cdb_en, lpreg(0), lpreg(1)); end
        total++; if (bus.in_ready !== 4'b1101) begin bad++; $display("FAIL bp_full_ready got=%b exp=1101", bus.in_ready); end
        clear_in();
        drive(1, 6'h23, 5'd3, 32'h0);
        tick();
        clear_in();
        total++; if (bus.cdb_en !== 2'b01 || lpreg(0) !== 6'h21) begin bad++; $display("FAIL bp_drain1 got=%b %h exp=01 21", bus.cdb_en, lpreg(0)); end
        total++; if (bus.in_ready !== 4'hF) begin bad++; $display("FAIL bp_third_rejected ready=%b exp=1111", bus.in_ready); end
        tick();
        total++; if (bus.cdb_en !== 2'b01 || lpreg(0) !== 6'h22) begin bad++; $display("FAIL bp_drain2 got=%b %h exp=01 22", bus.cdb_en, lpreg(0)); end
        tick();
        total++; if (bus.cdb_en !== 2'b00) begin bad++; $display("FAIL bp_no_third got=%b %h exp=00", bus.cdb_en, lpreg(0)); end
    endtask

    task automatic test_fairness();
        int g [N_CH];
        int sum;
        do_reset();
        for (int c = 0; c < N_CH; c++) begin
            g[c] = 0;
            drive(c, PREG_W'(6'h10 + c), ROB_W'(c), XLEN'(c));
        end
        tick();
        tick();
        for (int k = 0; k < 8; k++) begin
            for (int l = 0; l < N_CDB; l++) begin
                if (bus.cdb_en[l] && lpreg(l) >= 6'h10 && lpreg(l) <= 6'h13) g[int'(lpreg(l)) - 16]++;
            end
            tick();
        end
        clear_in();
        sum = 0;
        for (int c = 0; c < N_CH; c++) begin
            sum += g[c];
            total++; if (g[c] != 4) begin bad++; $display("FAIL fair_ch%0d got=%0d exp=4", c, g[c]); end
        end
        total++; if (sum != 16) begin bad++; $display("FAIL fair_total got=%0d exp=16", sum); end
    endtask

    task automatic test_squash();
        do_reset();
        for (int c = 0; c < N_CH; c++) drive(c, PREG_W'(6'h30 + c), ROB_W'(c), XLEN'(c));
        tick();
        clear_in();
        drive(0, 6'h38, 5'd8, 32'h0);
        drive(2, 6'h3A, 5'd10, 32'h0);
        drive(3, 6'h3B, 5'd11, 32'h0);
        tick();
        total++; if (bus.cdb_en !== 2'b11 || lpreg(0) !== 6'h30) begin bad++; $display("FAIL sq_pre got=%b %h exp=11 30", bus.cdb_en, lpreg(0)); end
        clear_in();
        drive(1, 6'h3F, 5'd15, 32'h0);
        squash = 1'b1;
        tick();
        squash = 1'b0;
        clear_in();
        total++; if (bus.cdb_en !== 2'b00 || bus.cdb_preg !== '0) begin bad++; $display("FAIL sq_clear got=%b %h exp=00 0", bus.cdb_en, bus.cdb_preg); end
        total++; if (bus.in_ready !== 4'hF) begin bad++; $display("FAIL sq_ready got=%h exp=f", bus.in_ready); end
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (bus.cdb_en !== 2'b00) begin bad++; $display("FAIL sq_leak%0d got=%b %h exp=00", k, bus.cdb_en, bus.cdb_preg); end
        end
        // rr_ptr kept at 2: channel 2 outranks channel 0
        drive(0, 6'h01, 5'd0, 32'h0);
        drive(2, 6'h02, 5'd0, 32'h0);
        tick();
        clear_in();
        tick();
        total++; if (bus.cdb_en !== 2'b11 || lpreg(0) !== 6'h02 || lpreg(1) !== 6'h01) begin bad++; $display("FAIL sq_rr_kept got=%b %h %h exp=11 02 01", bus.cdb_en, lpreg(0), lpreg(1)); end
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int c = 0; c < N_CH; c++) drive(c, PREG_W'(6'h20 + c), ROB_W'(c), 32'hFFFF_0000);
        tick();
        tick();
        total++; if (bus.cdb_en !== 2'b11) begin bad++; $display("FAIL ar_burst got=%b exp=11", bus.cdb_en); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (bus.cdb_en !== 2'b00 || bus.cdb_preg !== '0 || bus.out_result !== '0 || bus.out_rob_idx !== '0) begin bad++; $display("FAIL ar_async got=%b %h %h exp=00 0 0", bus.cdb_en, bus.cdb_preg, bus.out_result); end
        total++; if (bus.in_ready !== 4'hF) begin bad++; $display("FAIL ar_ready got=%h exp=f", bus.in_ready); end
        clear_in();
        #2;
        reset = 1'b1;
        single_push("post_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_channels();
        test_backpressure();
        test_fairness();
        test_squash();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
